// File: rtl/rsa_sc_pkg.sv
// Shared constants for the two-copy RSA self-composition run controller.
package rsa_sc_pkg;

    // Default build parameters: prime width, latency counter width, run cap.
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 50000;

    // Controller states; kept as plain constants so the encoding stays stable.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CLEAR  = 3'd1;
    localparam state_t ST_LAUNCH = 3'd2;
    localparam state_t ST_RUN    = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    // Latency reported for a copy that never finished before the run cap.
    localparam logic [DEF_CNT_W-1:0] CYC_NONE = '1;

endpackage

// File: rtl/rsa_sc_timing_ctrl_capture.sv
// First-finish latency/result capture for one RSA copy.
// Records the counter value and decrypted result on the first finish seen
// while enabled; later finish activity is ignored until the next clear.
module rsa_lat_capture
    import rsa_sc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic               finish,
    input  logic [CNT_W-1:0]   cnt,
    input  logic [2*WIDTH-1:0] result,
    output logic               cap,
    output logic [CNT_W-1:0]   cyc,
    output logic [2*WIDTH-1:0] res
);

    // Capture once per run; clr wipes the previous run's record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap <= 1'b0;
            cyc <= '0;
            res <= '0;
        end else if (clr) begin
            cap <= 1'b0;
            cyc <= '0;
            res <= '0;
        end else if (en && finish && !cap) begin
            cap <= 1'b1;
            cyc <= cnt;
            res <= result;
        end
    end

endmodule

// File: rtl/rsa_sc_timing_ctrl.sv
// Run controller for the two-copy RSA self-composition.
// One run: latch operands, reset both copies for a cycle, launch key
// generation on both together, time each copy to its first finish, then
// report latencies plus timing-leak and result-mismatch flags.
// Handshake: run_start is a level request sampled only in IDLE; done is a
// one-cycle pulse and results hold until the next accepted run_start.
module rsa_sc_timing_ctrl
    import rsa_sc_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_start,
    input  logic [WIDTH-1:0]   p_1_in,
    input  logic [WIDTH-1:0]   q_1_in,
    input  logic [WIDTH-1:0]   p_2_in,
    input  logic [WIDTH-1:0]   q_2_in,
    input  logic [2*WIDTH-1:0] m_in,
    output logic [WIDTH-1:0]   p_1,
    output logic [WIDTH-1:0]   q_1,
    output logic [WIDTH-1:0]   p_2,
    output logic [WIDTH-1:0]   q_2,
    output logic [2*WIDTH-1:0] m,
    output logic               rsa_rst_n,
    output logic               KeyGenStart,
    input  logic               finish_1,
    input  logic               finish_2,
    input  logic [2*WIDTH-1:0] m_decrypted_1,
    input  logic [2*WIDTH-1:0] m_decrypted_2,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   cyc_1,
    output logic [CNT_W-1:0]   cyc_2,
    output logic               leak,
    output logic               msg_mismatch,
    output logic               timeout,
    output logic [2:0]         state_dbg
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_t             state;
    logic               clr_n;
    logic [CNT_W-1:0]   cnt;
    logic               cap_1, cap_2;
    logic [CNT_W-1:0]   cyc_c1, cyc_c2;
    logic [2*WIDTH-1:0] res_1, res_2;
    logic               start_ok;
    logic               run_en;
    logic               both_cap;

    assign start_ok    = (state == ST_IDLE) && run_start;
    assign run_en      = (state == ST_RUN);
    // Both copies captured, counting captures landing this very cycle.
    assign both_cap    = (cap_1 | finish_1) & (cap_2 | finish_2);

    assign rsa_rst_n   = rst_n & clr_n;
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign KeyGenStart = (state == ST_LAUNCH);
    assign state_dbg   = state;

    // A copy left uncaptured by an aborted run reports all ones.
    assign cyc_1 = (timeout && !cap_1) ? '1 : cyc_c1;
    assign cyc_2 = (timeout && !cap_2) ? '1 : cyc_c2;

    rsa_lat_capture #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cap_1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start_ok),
        .en     (run_en),
        .finish (finish_1),
        .cnt    (cnt),
        .result (m_decrypted_1),
        .cap    (cap_1),
        .cyc    (cyc_c1),
        .res    (res_1)
    );

    rsa_lat_capture #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cap_2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start_ok),
        .en     (run_en),
        .finish (finish_2),
        .cnt    (cnt),
        .result (m_decrypted_2),
        .cap    (cap_2),
        .cyc    (cyc_c2),
        .res    (res_2)
    );

    // Run sequencing, operand latching, cycle counting and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            clr_n        <= 1'b1;
            cnt          <= '0;
            p_1          <= '0;
            q_1          <= '0;
            p_2          <= '0;
            q_2          <= '0;
            m            <= '0;
            timeout      <= 1'b0;
            leak         <= 1'b0;
            msg_mismatch <= 1'b0;
        end else begin
            clr_n <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (run_start) begin
                        p_1          <= p_1_in;
                        q_1          <= q_1_in;
                        p_2          <= p_2_in;
                        q_2          <= q_2_in;
                        m            <= m_in;
                        cnt          <= '0;
                        timeout      <= 1'b0;
                        leak         <= 1'b0;
                        msg_mismatch <= 1'b0;
                        clr_n        <= 1'b0;
                        state        <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    state <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    // Counter reads 1 in the first RUN cycle.
                    cnt   <= CNT_W'(1);
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (both_cap) begin
                        state <= ST_DONE;
                    end else if (cnt == TO_CNT) begin
                        timeout <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    leak         <= (cyc_1 != cyc_2);
                    msg_mismatch <= cap_1 & cap_2 & (res_1 != res_2);
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_sc_timing_ctrl.sv
// Bench for rsa_sc_timing_ctrl: stub RSA copies with programmable finish
// latency, directed and randomized runs checked against a latency model.
module tb_rsa_sc_timing_ctrl;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 100;
    localparam int W       = 2 * WIDTH;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic             run_start;
    logic [WIDTH-1:0] p_1_in, q_1_in, p_2_in, q_2_in;
    logic [W-1:0]     m_in;
    logic [WIDTH-1:0] p_1, q_1, p_2, q_2;
    logic [W-1:0]     m;
    logic             rsa_rst_n, KeyGenStart;
    logic             finish_1, finish_2;
    logic [W-1:0]     m_decrypted_1, m_decrypted_2;
    logic             busy, done, leak, msg_mismatch, timeout;
    logic [CNT_W-1:0] cyc_1, cyc_2;
    logic [2:0]       state_dbg;

    rsa_sc_timing_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .run_start(run_start),
        .p_1_in(p_1_in), .q_1_in(q_1_in), .p_2_in(p_2_in), .q_2_in(q_2_in),
        .m_in(m_in), .p_1(p_1), .q_1(q_1), .p_2(p_2), .q_2(q_2), .m(m),
        .rsa_rst_n(rsa_rst_n), .KeyGenStart(KeyGenStart),
        .finish_1(finish_1), .finish_2(finish_2),
        .m_decrypted_1(m_decrypted_1), .m_decrypted_2(m_decrypted_2),
        .busy(busy), .done(done), .cyc_1(cyc_1), .cyc_2(cyc_2),
        .leak(leak), .msg_mismatch(msg_mismatch), .timeout(timeout),
        .state_dbg(state_dbg)
    );

    // ---------------- stub RSA copies ----------------
    // Each copy finishes lat_k cycles after the KeyGenStart pulse (0 = never).
    // preset_k plants a stale finish that only the copy reset removes.
    int           lat_1, lat_2;
    logic         preset_1, preset_2;
    logic [W-1:0] flip_2;
    logic         go_1, go_2, stale_1, stale_2;
    int           ctr_1, ctr_2;

    always @(posedge clk or negedge rsa_rst_n) begin
        if (!rsa_rst_n) begin
            go_1 <= 1'b0; ctr_1 <= 0; stale_1 <= 1'b0;
        end else begin
            if (preset_1) stale_1 <= 1'b1;
            if (KeyGenStart) begin go_1 <= 1'b1; ctr_1 <= 1; end
            else if (go_1) ctr_1 <= ctr_1 + 1;
        end
    end

    always @(posedge clk or negedge rsa_rst_n) begin
        if (!rsa_rst_n) begin
            go_2 <= 1'b0; ctr_2 <= 0; stale_2 <= 1'b0;
        end else begin
            if (preset_2) stale_2 <= 1'b1;
            if (KeyGenStart) begin go_2 <= 1'b1; ctr_2 <= 1; end
            else if (go_2) ctr_2 <= ctr_2 + 1;
        end
    end

    assign finish_1      = stale_1 | (go_1 && lat_1 != 0 && ctr_1 >= lat_1);
    assign finish_2      = stale_2 | (go_2 && lat_2 != 0 && ctr_2 >= lat_2);
    assign m_decrypted_1 = m;
    assign m_decrypted_2 = m ^ flip_2;

    int kgs_total;
    always @(posedge clk) if (KeyGenStart === 1'b1) kgs_total++;

    // ---------------- scoreboard ----------------
    int checks;
    int failures;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Expected run outcome from the latency rules:
    // {cyc_1, cyc_2, done_latency, 13'b0, timeout, leak, msg_mismatch}
    function automatic logic [63:0] model(input int l1, input int l2, input bit differ);
        bit          c1, c2, to;
        logic [15:0] e1, e2, lat;
        c1  = (l1 > 0) && (l1 <= TIMEOUT);
        c2  = (l2 > 0) && (l2 <= TIMEOUT);
        e1  = c1 ? 16'(l1) : 16'hFFFF;
        e2  = c2 ? 16'(l2) : 16'hFFFF;
        to  = !(c1 && c2);
        lat = to ? 16'(3 + TIMEOUT) : 16'(3 + ((l1 > l2) ? l1 : l2));
        return {e1, e2, lat, 13'b0, to, (e1 != e2), (c1 && c2 && differ)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_done(output int c);
        c = 1;
        while (done !== 1'b1 && c < 3 + TIMEOUT + 20) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic run_case(input string tag, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                            input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] b2,
                            input logic [W-1:0] msg, input int l1, input int l2,
                            input logic [W-1:0] fl);
        logic [63:0] e;
        int c, k0;
        lat_1 = l1; lat_2 = l2; flip_2 = fl;
        exp_q.push_back(model(l1, l2, fl != '0));
        k0 = kgs_total;
        @(negedge clk);
        p_1_in = a1; q_1_in = b1; p_2_in = a2; q_2_in = b2; m_in = msg;
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        check({tag, "_clear_busy"}, busy, 1);
        check({tag, "_clear_rsa_rst_n"}, rsa_rst_n, 0);
        wait_done(c);
        e = exp_q.pop_front();
        check({tag, "_done"}, done, 1);
        check({tag, "_latency"}, c, e[31:16]);
        check({tag, "_cyc_1"}, cyc_1, e[63:48]);
        check({tag, "_cyc_2"}, cyc_2, e[47:32]);
        check({tag, "_timeout"}, timeout, e[2]);
        check({tag, "_ops"}, {p_1, q_1, p_2, q_2, m}, {a1, b1, a2, b2, msg});
        check({tag, "_kgs_pulses"}, kgs_total - k0, 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_leak"}, leak, e[1]);
        check({tag, "_mismatch"}, msg_mismatch, e[0]);
        check({tag, "_hold_cyc_1"}, cyc_1, e[63:48]);
    endtask

    // ---------------- directed and random steps ----------------
    initial begin
        int c, d, k0, l1, l2;
        logic [W-1:0] fl;
        checks = 0; failures = 0; kgs_total = 0;
        rst_n = 1'b0; run_start = 1'b0;
        p_1_in = '0; q_1_in = '0; p_2_in = '0; q_2_in = '0; m_in = '0;
        lat_1 = 0; lat_2 = 0; preset_1 = 1'b0; preset_2 = 1'b0; flip_2 = '0;

        // reset state
        #12;
        check("rst_rsa_rst_n", rsa_rst_n, 0);
        check("rst_outs", {busy, done, KeyGenStart, leak, msg_mismatch, timeout}, 0);
        check("rst_regs", {p_1, q_1, p_2, q_2, m, cyc_1, cyc_2}, 0);
        check("rst_state", state_dbg, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_rsa_rst_n", rsa_rst_n, 1);

        // directed runs, including the TIMEOUT boundary
        run_case("equal40", 8'd61, 8'd53, 8'd61, 8'd53, 16'd65, 40, 40, '0);
        run_case("skew47", 8'd61, 8'd53, 8'd61, 8'd53, 16'd65, 40, 47, '0);
        run_case("never2", 8'd61, 8'd53, 8'd59, 8'd47, 16'd1234, 40, 0, '0);
        run_case("flip1", 8'd61, 8'd53, 8'd61, 8'd53, 16'd65, 40, 40, 16'h0001);
        run_case("both_at_to", 8'd11, 8'd13, 8'd17, 8'd19, 16'hBEEF, TIMEOUT, TIMEOUT, '0);
        run_case("one_at_to", 8'd11, 8'd13, 8'd17, 8'd19, 16'hBEEF, TIMEOUT, 0, 16'h0100);
        run_case("late2", 8'd7, 8'd5, 8'd3, 8'd2, 16'h00FF, 1, TIMEOUT + 5, '0);

        // randomized runs
        for (int i = 0; i < 6; i++) begin
            l1 = $urandom_range(60, 1);
            l2 = ($urandom_range(1, 0) == 1) ? l1 : $urandom_range(60, 1);
            fl = ($urandom_range(1, 0) == 1) ? W'(1) << $urandom_range(W - 1, 0) : '0;
            run_case("rand", WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                     WIDTH'($urandom), W'($urandom), l1, l2, fl);
        end

        // stale finish planted before the run must be dropped by CLEAR
        @(negedge clk) begin preset_1 = 1'b1; preset_2 = 1'b1; end
        @(negedge clk) begin preset_1 = 1'b0; preset_2 = 1'b0; end
        check("stale_planted", {finish_1, finish_2}, 2'b11);
        run_case("stale", 8'd61, 8'd53, 8'd61, 8'd53, 16'd65, 40, 40, '0);

        // run_start held high: one run per IDLE visit, restart right after DONE
        lat_1 = 40; lat_2 = 40; flip_2 = '0;
        @(negedge clk) run_start = 1'b1;
        c = 0;
        while (done !== 1'b1 && c < 200) begin @(negedge clk); c++; end
        check("hold_first_latency", c, 43);
        @(negedge clk);
        check("hold_idle_gap", busy, 0);
        k0 = kgs_total;
        d = 1;
        while (done !== 1'b1 && d < 200) begin @(negedge clk); d++; end
        run_start = 1'b0;
        check("hold_done_spacing", d, 44);
        check("hold_kgs_pulses", kgs_total - k0, 1);
        repeat (2) @(negedge clk);
        check("hold_no_third_run", busy, 0);

        // async reset mid-RUN at cnt=20, then a fresh run
        lat_1 = 40; lat_2 = 47;
        @(negedge clk) begin p_1_in = 8'd61; q_1_in = 8'd53; m_in = 16'hA5A5; run_start = 1'b1; end
        @(negedge clk) run_start = 1'b0;
        repeat (21) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_rsa_rst_n", rsa_rst_n, 0);
        check("midrst_outs", {busy, done, KeyGenStart, leak, msg_mismatch, timeout}, 0);
        check("midrst_regs", {p_1, q_1, p_2, q_2, m, cyc_1, cyc_2}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", {state_dbg, busy, rsa_rst_n}, {3'd0, 1'b0, 1'b1});
        run_case("after_rst", 8'd61, 8'd53, 8'd61, 8'd53, 16'd65, 33, 21, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rsa_sc_timing_ctrl.md
Name: rsa_sc_timing_ctrl

Overview:
Run controller for the two-copy RSA self-composition.
- Latches one operand set per run: secret primes for each copy plus a shared message.
- Clears both RSA copies, launches key generation on both in the same cycle, and counts cycles until each copy asserts finish.
- Reports both latencies, a timing-leak flag and a decrypted-result mismatch flag.
- Sits beside the two-copy wrapper and drives all of its inputs; it is the harness the side-channel checks run against.

Parameters:
WIDTH, 8, prime width; message/result width is 2*WIDTH
CNT_W, 16, latency counter width
TIMEOUT, 50000, max RUN cycles before abort; must be < 2^CNT_W

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
run_start  in  1  request a run; accepted only in IDLE
p_1_in, q_1_in  in  WIDTH  copy-1 primes
p_2_in, q_2_in  in  WIDTH  copy-2 primes
m_in  in  2*WIDTH  shared message
p_1, q_1, p_2, q_2  out  WIDTH  registered primes to the copies
m  out  2*WIDTH  registered message to the copies
rsa_rst_n  out  1  reset to both copies
KeyGenStart  out  1  launch pulse to both copies
finish_1, finish_2  in  1  copy finish flags
m_decrypted_1, m_decrypted_2  in  2*WIDTH  copy results
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse: results valid
cyc_1, cyc_2  out  CNT_W  measured latencies
leak  out  1  latencies differ
msg_mismatch  out  1  decrypted results differ
timeout  out  1  run aborted at TIMEOUT

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All registered outputs are 0: operands, KeyGenStart, busy, done, cyc_*, flags.
  - rsa_rst_n = rst_n & clr_n, where clr_n is a register reset to 1; rsa_rst_n is therefore low throughout reset.
- FSM: IDLE -> CLEAR -> LAUNCH -> RUN -> DONE -> IDLE.
- IDLE:
  - On run_start=1: latch p/q/m inputs into the output registers.
  - Clear cyc_*, leak, msg_mismatch and timeout; clear counter cnt.
  - Go to CLEAR.
  - run_start in any other state, including DONE, is ignored (no queueing).
- CLEAR: exactly 1 cycle with clr_n=0 (rsa_rst_n low), which drops stale finish flags. Operands stay stable.
- LAUNCH: exactly 1 cycle with KeyGenStart=1 and clr_n=1.
- RUN:
  - cnt increments every cycle; it is 1 in the first RUN cycle.
  - First cycle with finish_k=1 and cap_k=0: cyc_k<=cnt, res_k<=m_decrypted_k, cap_k<=1.
  - Later finish_k activity is ignored.
  - Both copies may capture in the same cycle; they get equal cyc values.
  - Exit to DONE when cap_1&cap_2, either already set or set in this cycle.
  - Otherwise, if cnt==TIMEOUT, set timeout=1 and exit to DONE. An uncaptured copy reports cyc_k = all ones.
- DONE: 1 cycle.
  - done=1.
  - leak <= (cyc_1!=cyc_2).
  - msg_mismatch <= cap_1&cap_2&(res_1!=res_2).
  - Next state is IDLE.
- Result outputs and flags hold their values until the next accepted run_start.
- busy=1 in CLEAR, LAUNCH, RUN and DONE.
- Latency from accepted run_start to done = 3 + max(cyc_1,cyc_2) cycles (or 3+TIMEOUT on abort).
- cnt never wraps: the TIMEOUT bound holds.
- rst_n asserted mid-run: immediate abort to reset values; the copies are reset through rsa_rst_n.

Decomposition:
- Package rsa_sc_pkg:
  - state enum: IDLE, CLEAR, LAUNCH, RUN, DONE.
  - default constants: WIDTH, CNT_W, TIMEOUT.
  - CYC_NONE = all ones.
- One sub-module, rsa_lat_capture, instantiated once per copy:
  - Inputs: clk, rst_n, clr, en, finish, cnt, result.
  - Outputs: cap, cyc, res.
  - Holds the first-finish capture logic.

Test Plan:
- Identical primes p=61, q=53 both copies with stub copies finishing after 40 cycles -> cyc_1=cyc_2=40, leak=0, msg_mismatch=0, done 43 cycles after start, KeyGenStart a single pulse.
- Stub copy 1 finishing at 40 and copy 2 at 47 -> cyc_1=40, cyc_2=47, leak=1, done 50 cycles after start.
- Stub copy 2 never finishing, TIMEOUT=100 -> timeout=1, cyc_1=40, cyc_2=16'hFFFF, leak=1, msg_mismatch=0.
- Equal latency, m_decrypted_2 differing by one bit -> leak=0, msg_mismatch=1.
- run_start held high through the whole run -> exactly one run per IDLE visit. A second start asserted during RUN is ignored; run_start still high in IDLE begins a new run the cycle after DONE.
- rst_n pulsed low mid-RUN at cnt=20 -> all outputs 0 and rsa_rst_n low immediately; after release, state IDLE and a fresh run measures correctly. Also check a stale finish held high before the run is cleared by CLEAR and not captured.
